hough_accumulator: RTL and testbench

- Vote-accumulation stage directly downstream of the Hough transform FSM (FSMHough).
- Each write_enable pulse carries one (rho, theta) vote. The block increments the matching bin in an internal accumulator RAM.
- On end of frame it scans the RAM, reports the strongest line (rho, theta, votes), then clears the RAM for the next frame.

---
 rtl/hough_pkg.sv | 26 ++
 rtl/hough_vote_ram.sv | 28 ++
 rtl/hough_accumulator.sv | 250 +++++++++++++++++++++++++
 tb/tb_hough_accumulator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hough_pkg.sv
// Shared definitions for the Hough vote accumulator and its upstream FSM.
package hough_pkg;

    localparam int HOUGH_THETA_W    = 8;
    localparam int HOUGH_THETA_BINS = 180;
    localparam int HOUGH_RHO_W      = 11;
    localparam int HOUGH_RHO_OFFSET = 1024;
    localparam int HOUGH_VOTE_W     = 10;
    localparam int HOUGH_DROP_W     = 16;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_ACCUM,
        ST_FLUSH,
        ST_SCAN,
        ST_DONE
    } hough_state_e;

    // Bin address is {theta, rho_index}: theta selects a row of 2^rho_w bins.
    function automatic logic [31:0] hough_bin_addr(input logic [31:0] theta,
                                                   input logic [31:0] rho_idx,
                                                   input int          rho_w);
        return (theta << rho_w) | rho_idx;
    endfunction

endpackage

// File: rtl/hough_vote_ram.sv
// Simple dual-port vote RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old data.
module hough_vote_ram #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 10
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Write port and 1-cycle synchronous read port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/hough_accumulator.sv
// Hough vote accumulator: counts (rho, theta) votes per frame, then scans the
// bins for the strongest line, reports it, and clears the RAM for the next frame.
module hough_accumulator
    import hough_pkg::*;
#(
    parameter int THETA_W    = HOUGH_THETA_W,
    parameter int THETA_BINS = HOUGH_THETA_BINS,
    parameter int RHO_W      = HOUGH_RHO_W,
    parameter int RHO_OFFSET = HOUGH_RHO_OFFSET,
    parameter int VOTE_W     = HOUGH_VOTE_W
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic signed [RHO_W-1:0]        address,
    input  logic        [THETA_W-1:0]      theta,
    input  logic                           write_enable,
    input  logic                           frame_end,
    output logic                           busy,
    output logic                           peak_valid,
    output logic signed [RHO_W-1:0]        peak_rho,
    output logic        [THETA_W-1:0]      peak_theta,
    output logic        [VOTE_W-1:0]       peak_votes,
    output logic        [HOUGH_DROP_W-1:0] dropped
);

    localparam int                ADDR_W    = THETA_W + RHO_W;
    localparam logic [ADDR_W-1:0] CLR_LAST  = '1;
    localparam logic [ADDR_W-1:0] SCAN_LAST = ADDR_W'(THETA_BINS * (2**RHO_W) - 1);
    localparam logic [VOTE_W-1:0] VOTE_MAX  = '1;

    hough_state_e state_q, state_d;

    logic [ADDR_W-1:0]       clr_addr_q, clr_addr_d;
    logic                    flush_cnt_q, flush_cnt_d;
    logic [ADDR_W-1:0]       scan_addr_q, scan_addr_d;
    logic                    scan_done_q, scan_done_d;
    logic                    scan_rd_q, scan_rd_d;
    logic [ADDR_W-1:0]       scan_rd_addr_q, scan_rd_addr_d;
    logic [VOTE_W-1:0]       max_votes_q, max_votes_d;
    logic [ADDR_W-1:0]       max_addr_q, max_addr_d;
    logic signed [RHO_W-1:0] peak_rho_q, peak_rho_d;
    logic [THETA_W-1:0]      peak_theta_q, peak_theta_d;
    logic [VOTE_W-1:0]       peak_votes_q, peak_votes_d;
    logic [HOUGH_DROP_W-1:0] dropped_q, dropped_d;

    // Vote pipeline: S0 holds the vote whose read is in flight, S1 remembers
    // the write made on the previous edge for forwarding.
    logic              s0_vld_q, s0_vld_d;
    logic [ADDR_W-1:0] s0_addr_q, s0_addr_d;
    logic              s1_vld_q, s1_vld_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [VOTE_W-1:0] s1_data_q, s1_data_d;

    logic signed [31:0] rho_sum;
    logic               rho_ok;
    logic               theta_ok;
    logic [ADDR_W-1:0]  vote_addr;
    logic               vote_acc;
    logic               vote_drop;
    logic [VOTE_W-1:0]  s0_base;
    logic [VOTE_W-1:0]  s0_inc;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [VOTE_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [VOTE_W-1:0] ram_rdata;

    // Range check and bin address of the incoming vote.
    always_comb begin
        rho_sum   = 32'(address) + 32'(RHO_OFFSET);
        rho_ok    = (rho_sum[31:RHO_W] == '0);
        theta_ok  = (32'(theta) < 32'(THETA_BINS));
        vote_addr = ADDR_W'(hough_bin_addr(32'(theta), 32'(rho_sum[RHO_W-1:0]), RHO_W));
        vote_acc  = write_enable && (state_q == ST_ACCUM) && rho_ok && theta_ok;
        vote_drop = write_enable && !vote_acc;
    end

    // Read-modify-write: forward the previous write when it hit the same bin,
    // since the RAM returned the pre-write value for that read.
    always_comb begin
        s0_base   = (s1_vld_q && (s1_addr_q == s0_addr_q)) ? s1_data_q : ram_rdata;
        s0_inc    = (s0_base == VOTE_MAX) ? s0_base : s0_base + VOTE_W'(1);
        s0_vld_d  = vote_acc;
        s0_addr_d = vote_addr;
        s1_vld_d  = s0_vld_q;
        s1_addr_d = s0_addr_q;
        s1_data_d = s0_inc;
    end

    // RAM port steering: CLEAR owns the write port, SCAN owns the read port.
    always_comb begin
        ram_we    = s0_vld_q;
        ram_waddr = s0_addr_q;
        ram_wdata = s0_inc;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = '0;
        end
        ram_raddr = (state_q == ST_SCAN) ? scan_addr_q : vote_addr;
    end

    // Frame FSM: clear, accumulate, drain, scan for the maximum, report.
    always_comb begin
        state_d        = state_q;
        clr_addr_d     = clr_addr_q;
        flush_cnt_d    = flush_cnt_q;
        scan_addr_d    = scan_addr_q;
        scan_done_d    = scan_done_q;
        scan_rd_d      = 1'b0;
        scan_rd_addr_d = scan_addr_q;
        max_votes_d    = max_votes_q;
        max_addr_d     = max_addr_q;
        peak_rho_d     = peak_rho_q;
        peak_theta_d   = peak_theta_q;
        peak_votes_d   = peak_votes_q;
        dropped_d      = dropped_q;

        if (vote_drop && (dropped_q != '1)) begin
            dropped_d = dropped_q + HOUGH_DROP_W'(1);
        end

        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == CLR_LAST) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (frame_end) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q) begin
                    state_d     = ST_SCAN;
                    scan_addr_d = '0;
                    scan_done_d = 1'b0;
                    max_votes_d = '0;
                    max_addr_d  = '0;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!scan_done_q) begin
                    scan_rd_d      = 1'b1;
                    scan_rd_addr_d = scan_addr_q;
                    if (scan_addr_q == SCAN_LAST) begin
                        scan_done_d = 1'b1;
                    end else begin
                        scan_addr_d = scan_addr_q + ADDR_W'(1);
                    end
                end
                if (scan_rd_q) begin
                    // Strict compare keeps the lowest address on ties.
                    if (ram_rdata > max_votes_q) begin
                        max_votes_d = ram_rdata;
                        max_addr_d  = scan_rd_addr_q;
                    end
                    if (scan_rd_addr_q == SCAN_LAST) begin
                        state_d      = ST_DONE;
                        peak_votes_d = max_votes_d;
                        peak_theta_d = max_addr_d[ADDR_W-1:RHO_W];
                        peak_rho_d   = max_addr_d[RHO_W-1:0] - RHO_W'(RHO_OFFSET);
                    end
                end
            end
            ST_DONE: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
                dropped_d  = '0;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // FSM, scan and report registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_CLEAR;
            clr_addr_q     <= '0;
            flush_cnt_q    <= 1'b0;
            scan_addr_q    <= '0;
            scan_done_q    <= 1'b0;
            scan_rd_q      <= 1'b0;
            scan_rd_addr_q <= '0;
            max_votes_q    <= '0;
            max_addr_q     <= '0;
            peak_rho_q     <= '0;
            peak_theta_q   <= '0;
            peak_votes_q   <= '0;
            dropped_q      <= '0;
        end else begin
            state_q        <= state_d;
            clr_addr_q     <= clr_addr_d;
            flush_cnt_q    <= flush_cnt_d;
            scan_addr_q    <= scan_addr_d;
            scan_done_q    <= scan_done_d;
            scan_rd_q      <= scan_rd_d;
            scan_rd_addr_q <= scan_rd_addr_d;
            max_votes_q    <= max_votes_d;
            max_addr_q     <= max_addr_d;
            peak_rho_q     <= peak_rho_d;
            peak_theta_q   <= peak_theta_d;
            peak_votes_q   <= peak_votes_d;
            dropped_q      <= dropped_d;
        end
    end

    // Vote pipeline registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            s0_vld_q  <= 1'b0;
            s0_addr_q <= '0;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_data_q <= '0;
        end else begin
            s0_vld_q  <= s0_vld_d;
            s0_addr_q <= s0_addr_d;
            s1_vld_q  <= s1_vld_d;
            s1_addr_q <= s1_addr_d;
            s1_data_q <= s1_data_d;
        end
    end

    hough_vote_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (VOTE_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    assign busy       = (state_q != ST_ACCUM);
    assign peak_valid = (state_q == ST_DONE);
    assign peak_rho   = peak_rho_q;
    assign peak_theta = peak_theta_q;
    assign peak_votes = peak_votes_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_hough_accumulator.sv
// Scoreboard bench for hough_accumulator with a small geometry
// (theta 0..5 of 3 bits, rho 4 bits signed, offset 8, 4-bit counters).
module tb_hough_accumulator;

    logic              clock = 1'b0;
    logic              reset;
    logic signed [3:0] address;
    logic [2:0]        theta;
    logic              write_enable;
    logic              frame_end;
    logic              busy;
    logic              peak_valid;
    logic signed [3:0] peak_rho;
    logic [2:0]        peak_theta;
    logic [3:0]        peak_votes;
    logic [15:0]       dropped;

    typedef struct {
        int rho;
        int theta;
        int votes;
        int dropped;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    hough_accumulator #(
        .THETA_W    (3),
        .THETA_BINS (6),
        .RHO_W      (4),
        .RHO_OFFSET (8),
        .VOTE_W     (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .theta        (theta),
        .write_enable (write_enable),
        .frame_end    (frame_end),
        .busy         (busy),
        .peak_valid   (peak_valid),
        .peak_rho     (peak_rho),
        .peak_theta   (peak_theta),
        .peak_votes   (peak_votes),
        .dropped      (dropped)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every peak_valid cycle must match the oldest expected report.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (peak_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_peak: got peak_valid=1 (rho %0d theta %0d votes %0d), expected no report",
                         peak_rho, peak_theta, peak_votes);
            end else begin
                e = exp_q.pop_front();
                check("peak_rho", int'(peak_rho), e.rho);
                check("peak_theta", int'(peak_theta), e.theta);
                check("peak_votes", int'(peak_votes), e.votes);
                check("dropped", int'(dropped), e.dropped);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic vote(input int rho, input int th);
        address      = 4'(rho);
        theta        = 3'(th);
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic wait_accum(input string name);
        int n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        compared++;
        if (busy) begin
            mismatched++;
            $display("FAIL %s: got busy=1 after %0d cycles, expected busy=0", name, n);
        end
    endtask

    task automatic wait_peak(input string name);
        int n = 0;
        while (!peak_valid && n < 1000) begin
            tick();
            n++;
        end
        compared++;
        if (!peak_valid) begin
            mismatched++;
            $display("FAIL %s: got no peak_valid within %0d cycles, expected a pulse", name, n);
        end
    endtask

    initial begin
        int n;
        reset        = 1'b1;
        address      = '0;
        theta        = '0;
        write_enable = 1'b0;
        frame_end    = 1'b0;
        repeat (3) tick();

        // 1. Reset state, then exactly 128 clear cycles.
        check("rst_busy", int'(busy), 1);
        check("rst_peak_valid", int'(peak_valid), 0);
        check("rst_peak_rho", int'(peak_rho), 0);
        check("rst_peak_theta", int'(peak_theta), 0);
        check("rst_peak_votes", int'(peak_votes), 0);
        check("rst_dropped", int'(dropped), 0);
        reset = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 1000);
        check("clear_cycles", n, 128);
        check("clear_dropped", int'(dropped), 0);

        // 2. Interleaved votes on non-consecutive cycles.
        exp_q.push_back('{2, 3, 3, 0});
        vote(2, 3);  tick();
        vote(2, 3);  tick();
        vote(-1, 0); tick();
        vote(2, 3);  tick();
        vote(-1, 0); tick();
        end_frame();
        wait_accum("accum_after_t2");

        // 3. Five back-to-back identical votes, frame_end with the fifth.
        exp_q.push_back('{-5, 1, 5, 0});
        address      = -4'sd5;
        theta        = 3'd1;
        write_enable = 1'b1;
        repeat (4) tick();
        frame_end = 1'b1;
        tick();
        write_enable = 1'b0;
        frame_end    = 1'b0;
        wait_peak("peak_t3");
        tick();

        // 4. Refused vote during CLEAR plus two out-of-range thetas.
        // rho = 8 has no 4-bit signed encoding, and every 4-bit rho + 8 lands
        // in 0..15, so theta = 7 is used as the second out-of-range vote.
        exp_q.push_back('{3, 2, 2, 3});
        vote(1, 1);
        wait_accum("accum_after_t3");
        check("dropped_clear_vote", int'(dropped), 1);
        vote(3, 2); tick();
        vote(0, 6); tick();
        vote(3, 2); tick();
        vote(0, 7); tick();
        end_frame();
        wait_accum("accum_after_t4");
        check("dropped_cleared", int'(dropped), 0);

        // 5a. Twenty votes into the last scanned bin saturate at 15.
        exp_q.push_back('{7, 5, 15, 0});
        address      = 4'sd7;
        theta        = 3'd5;
        write_enable = 1'b1;
        repeat (20) tick();
        write_enable = 1'b0;
        end_frame();
        wait_accum("accum_after_t5a");

        // 5b. Tie of 2 votes: theta = 0 bin beats theta = 4 bin.
        exp_q.push_back('{-3, 0, 2, 0});
        vote(3, 4); tick();
        vote(-3, 0);
        vote(3, 4);
        vote(-3, 0); tick();
        end_frame();
        wait_accum("accum_after_t5b");

        // Empty frame reports the all-zero default peak.
        exp_q.push_back('{-8, 0, 0, 0});
        end_frame();
        wait_accum("accum_after_empty");

        // 6. Reset in the middle of SCAN abandons the report.
        vote(4, 4);
        end_frame();
        repeat (20) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check("midscan_rst_votes", int'(peak_votes), 0);
        check("midscan_rst_busy", int'(busy), 1);
        wait_accum("accum_after_reset");
        exp_q.push_back('{0, 5, 1, 0});
        vote(0, 5);
        end_frame();
        wait_peak("peak_t6");
        repeat (5) tick();
        check("hold_peak_theta", int'(peak_theta), 5);
        check("hold_peak_votes", int'(peak_votes), 1);

        repeat (3) tick();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_peak: got %0d reports outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
